// File: rtl/dmem_ctrl.sv
// Data-memory controller for the RV32I data port. It accepts a load or store, drives a
// single-port RAM with 1-cycle read latency, and performs read-modify-write for SB/SH.
module dmem_ctrl #(
    parameter int DW = 32,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    input  logic [2:0]    req_op,
    input  logic          req_we,
    output logic          resp_valid,
    output logic [DW-1:0] resp_rdata,
    output logic          resp_err,
    output logic [AW-3:0] mem_addr,
    output logic          mem_re,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [2:0]    dbg_state
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready.
    // req_ready is high only in IDLE; the response is a one-cycle resp_valid pulse
    // that the requester must take, with no back-pressure.

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        RWAIT = 3'd2,
        WR    = 3'd3,
        RSP   = 3'd4
    } state_t;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    state_t        state, state_next;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wbuf_q;
    logic [2:0]    op_q;
    logic          we_q;
    logic [DW-1:0] rdata_q;
    logic          err_q;

    logic          accept;
    logic          illegal;
    logic [DW-1:0] load_fmt;
    logic [DW-1:0] merged;

    assign accept = req_valid && req_ready;

    always_comb begin
        illegal = 1'b0;
        case (req_op)
            OP_B:    illegal = 1'b0;
            OP_H:    illegal = req_addr[0];
            OP_W:    illegal = (req_addr[1:0] != 2'b00);
            OP_BU:   illegal = req_we;
            OP_HU:   illegal = req_we || req_addr[0];
            default: illegal = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (illegal)                         state_next = RSP;
                    else if (req_we && req_op == OP_W)   state_next = WR;
                    else                                 state_next = RD;
                end
            end
            RD:      state_next = RWAIT;
            RWAIT:   state_next = we_q ? WR : RSP;
            WR:      state_next = RSP;
            RSP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from state, so reset drops mem_re/mem_we immediately
    always_comb begin
        req_ready  = (state == IDLE);
        mem_re     = (state == RD);
        mem_we     = (state == WR);
        mem_addr   = (state == RD || state == WR) ? addr_q[AW-1:2] : '0;
        mem_wdata  = (state == WR) ? wbuf_q : '0;
        resp_valid = (state == RSP);
        resp_err   = (state == RSP) && err_q;
        resp_rdata = (state == RSP) ? rdata_q : '0;
        dbg_state  = state;
    end

    always_comb begin
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        lane_b = mem_rdata[8*addr_q[1:0] +: 8];
        lane_h = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (op_q[1:0])
            2'b00:   load_fmt = op_q[2] ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
            2'b01:   load_fmt = op_q[2] ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: load_fmt = mem_rdata;
        endcase
    end

    always_comb begin
        merged = mem_rdata;
        if (op_q[1:0] == 2'b00) begin
            merged[8*addr_q[1:0] +: 8] = wbuf_q[7:0];
        end else if (op_q[1:0] == 2'b01) begin
            if (addr_q[1]) merged[31:16] = wbuf_q[15:0];
            else           merged[15:0]  = wbuf_q[15:0];
        end
    end

    // Request latch and datapath; wbuf_q holds store data, then the merged RMW word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wbuf_q  <= '0;
            op_q    <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            addr_q  <= req_addr;
            wbuf_q  <= req_wdata;
            op_q    <= req_op;
            we_q    <= req_we;
            rdata_q <= '0;
            err_q   <= illegal;
        end else if (state == RWAIT) begin
            if (we_q) wbuf_q  <= merged;
            else      rdata_q <= load_fmt;
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: a small word RAM model with 1-cycle read latency and
// hand-computed expectations for loads, stores, RMW, errors, back-to-back and reset.
module tb_dmem_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_op;
    logic        req_we;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [29:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [2:0]  dbg_state;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] ram [0:15];

    dmem_ctrl #(.DW(32), .AW(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_op(req_op), .req_we(req_we),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: read data appears the cycle after mem_re
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= ram[mem_addr[3:0]];
        if (mem_we) ram[mem_addr[3:0]] <= mem_wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request for one accept edge; returns in cycle 1
    task automatic issue(input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] op, input logic we);
        req_addr  = a;
        req_wdata = d;
        req_op    = op;
        req_we    = we;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic store_word(input logic [31:0] a, input logic [31:0] d);
        issue(a, d, 3'b010, 1'b1);
        tick();
        tick();
    endtask

    task automatic load_check(input string tag, input logic [31:0] a, input logic [2:0] op,
                              input logic [31:0] exp);
        issue(a, 32'h0, op, 1'b0);
        check({tag, "_re"}, {31'd0, mem_re}, 32'd1);
        tick();
        check({tag, "_c2_valid"}, {31'd0, resp_valid}, 32'd0);
        tick();
        check({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
        check({tag, "_err"}, {31'd0, resp_err}, 32'd0);
        check({tag, "_rdata"}, resp_rdata, exp);
        tick();
    endtask

    task automatic err_check(input string tag, input logic [31:0] a, input logic [2:0] op,
                             input logic we);
        issue(a, 32'hFFFF_FFFF, op, we);
        check({tag, "_mem"}, {30'd0, mem_re, mem_we}, 32'd0);
        check({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
        check({tag, "_err"}, {31'd0, resp_err}, 32'd1);
        check({tag, "_rdata"}, resp_rdata, 32'd0);
        tick();
        check({tag, "_idle"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        int pulses;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_op    = '0;
        req_we    = 1'b0;
        #1;
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_outs", {28'd0, resp_valid, resp_err, mem_re, mem_we}, 32'd0);
        check("rst_addr", {2'd0, mem_addr}, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_state", {29'd0, dbg_state}, 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // SW 0x10
        issue(32'h10, 32'hDEAD_BEEF, 3'b010, 1'b1);
        check("sw_we", {30'd0, mem_re, mem_we}, 32'd1);
        check("sw_addr", {2'd0, mem_addr}, 32'h4);
        check("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("sw_busy", {31'd0, req_ready}, 32'd0);
        tick();
        check("sw_valid", {31'd0, resp_valid}, 32'd1);
        check("sw_err", {31'd0, resp_err}, 32'd0);
        check("sw_rdata", resp_rdata, 32'd0);
        tick();
        check("sw_done", {30'd0, resp_valid, req_ready}, 32'd1);
        load_check("lw_back", 32'h10, 3'b010, 32'hDEAD_BEEF);

        // Loads from 0x80FF1234
        store_word(32'h10, 32'h80FF_1234);
        load_check("lb13", 32'h13, 3'b000, 32'hFFFF_FF80);
        load_check("lbu13", 32'h13, 3'b100, 32'h0000_0080);
        load_check("lh12", 32'h12, 3'b001, 32'hFFFF_80FF);
        load_check("lhu10", 32'h10, 3'b101, 32'h0000_1234);
        load_check("lb10", 32'h10, 3'b000, 32'h0000_0034);
        load_check("lw10", 32'h10, 3'b010, 32'h80FF_1234);

        // SB RMW on 0x11223344
        store_word(32'h10, 32'h1122_3344);
        issue(32'h11, 32'h0000_00AA, 3'b000, 1'b1);
        check("sb_c1_re", {30'd0, mem_re, mem_we}, 32'd2);
        tick();
        check("sb_c2_idle_mem", {30'd0, mem_re, mem_we}, 32'd0);
        tick();
        check("sb_c3_we", {30'd0, mem_re, mem_we}, 32'd1);
        check("sb_c3_wdata", mem_wdata, 32'h1122_AA44);
        check("sb_c3_valid", {31'd0, resp_valid}, 32'd0);
        tick();
        check("sb_c4_valid", {31'd0, resp_valid}, 32'd1);
        check("sb_c4_err", {31'd0, resp_err}, 32'd0);
        tick();
        issue(32'h12, 32'h1234_BEEF, 3'b001, 1'b1);
        tick();
        tick();
        check("sh_wdata", mem_wdata, 32'hBEEF_AA44);
        tick();
        tick();
        load_check("lw_rmw", 32'h10, 3'b010, 32'hBEEF_AA44);

        // Illegal accesses
        err_check("lh13", 32'h13, 3'b001, 1'b0);
        err_check("op011", 32'h10, 3'b011, 1'b0);
        err_check("sbu", 32'h10, 3'b100, 1'b1);
        err_check("sw12", 32'h12, 3'b010, 1'b1);
        err_check("op111", 32'h10, 3'b111, 1'b1);
        load_check("lw_after_err", 32'h10, 3'b010, 32'hBEEF_AA44);

        // Back-to-back with req_valid held
        req_addr  = 32'h10;
        req_op    = 3'b010;
        req_we    = 1'b0;
        req_valid = 1'b1;
        tick();
        tick();
        tick();
        check("b2b_rsp1", {30'd0, resp_valid, req_ready}, 32'd2);
        check("b2b_rdata1", resp_rdata, 32'hBEEF_AA44);
        tick();
        check("b2b_idle", {30'd0, resp_valid, req_ready}, 32'd1);
        tick();
        check("b2b_second_acc", {30'd0, req_ready, mem_re}, 32'd1);
        req_valid = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (resp_valid) pulses++;
        end
        check("b2b_pulses", pulses, 32'd1);
        check("b2b_final_idle", {31'd0, req_ready}, 32'd1);

        // Reset mid-RMW: the write must never happen
        store_word(32'h10, 32'h1122_3344);
        issue(32'h10, 32'h0000_0055, 3'b000, 1'b1);
        check("mrst_pre_re", {31'd0, mem_re}, 32'd1);
        rst = 1'b1;
        #1;
        check("mrst_ready", {31'd0, req_ready}, 32'd1);
        check("mrst_outs", {29'd0, resp_valid, mem_re, mem_we}, 32'd0);
        check("mrst_state", {29'd0, dbg_state}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        load_check("mrst_lw", 32'h10, 3'b010, 32'h1122_3344);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
